// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter (instruction fetch, load/store) in front of a single
//   downstream memory controller. One transaction is in flight at a time:
//     IDLE -> IF_BUSY / LS_BUSY -> COOL -> IDLE
//   Load/store wins a same-cycle tie. A flushed fetch still completes
//   downstream, but its if_done pulse is swallowed.
//
//   Optional build macro: MEM_ARB_STARVE_GUARD_EN
//     When defined, a counter of load/store grants made while a fetch waits
//     forces a fetch grant once it reaches STARVE_LIMIT.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr/flush     fetch request side (flush kills the fetch result)
//   if_done/if_inst/if_done_addr   fetch completion (one-cycle pulse)
//   ls_req/ls_we/ls_addr/ls_wdata/ls_len/ls_signed   load/store request side
//   ls_done/ls_rdata         load/store completion (one-cycle pulse)
//   ctrl_if_req/ctrl_load/ctrl_save   downstream command levels
//   ctrl_addr/ctrl_wdata/ctrl_len/ctrl_signed   downstream operands
//   ctrl_inst_flag/ctrl_inst/ctrl_done/ctrl_data   downstream completions
//   dbg_state                current FSM state (IDLE=0 IF_BUSY=1 LS_BUSY=2 COOL=3)
//
// Handshake: a requester raises *_req and holds it until its *_done pulse.
// A command level stays high from grant until the cycle the downstream
// completion is sampled; operands are frozen for that whole window.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush,
   output logic              if_done,
   output logic [31:0]       if_inst,
   output logic [ADDR_W-1:0] if_done_addr,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   input  logic [2:0]        ls_len,
   input  logic              ls_signed,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   output logic              ctrl_if_req,
   output logic              ctrl_load,
   output logic              ctrl_save,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic [31:0]       ctrl_wdata,
   output logic [2:0]        ctrl_len,
   output logic              ctrl_signed,
   input  logic              ctrl_inst_flag,
   input  logic              ctrl_done,
   input  logic [31:0]       ctrl_inst,
   input  logic [31:0]       ctrl_data,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] IF_BUSY = 2'd1;
   localparam logic [1:0] LS_BUSY = 2'd2;
   localparam logic [1:0] COOL    = 2'd3;

   logic [1:0]        r_state;
   logic              r_kill;
   logic              r_if_done;
   logic [31:0]       r_if_inst;
   logic [ADDR_W-1:0] r_if_done_addr;
   logic              r_ls_done;
   logic [31:0]       r_ls_rdata;
   logic              r_ctrl_if_req;
   logic              r_ctrl_load;
   logic              r_ctrl_save;
   logic [ADDR_W-1:0] r_ctrl_addr;
   logic [31:0]       r_ctrl_wdata;
   logic [2:0]        r_ctrl_len;
   logic              r_ctrl_signed;

   logic              w_grant_if;
   logic              w_grant_ls;
   logic [2:0]        w_len_fix;

   // Only 1, 2 and 4 byte accesses exist downstream; anything else is a word.
   assign w_len_fix = (ls_len == 3'd1 || ls_len == 3'd2 || ls_len == 3'd4) ? ls_len : 3'd4;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int              CNT_W   = $clog2(STARVE_LIMIT + 2);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] r_starve_cnt;
   logic             w_starved;

   assign w_starved  = (r_starve_cnt == LIMIT_C);
   assign w_grant_if = if_req && (!ls_req || w_starved);

   // Counts load/store grants that overtook a waiting fetch. It cannot pass
   // the limit: at the limit a waiting fetch is always the winner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve_cnt <= '0;
      end else if (r_state == IDLE) begin
         if (w_grant_if)
            r_starve_cnt <= '0;
         else if (w_grant_ls && if_req)
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
   end
`else
   assign w_grant_if = if_req && !ls_req;
`endif

   assign w_grant_ls = ls_req && !w_grant_if;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_kill         <= 1'b0;
         r_if_done      <= 1'b0;
         r_if_inst      <= '0;
         r_if_done_addr <= '0;
         r_ls_done      <= 1'b0;
         r_ls_rdata     <= '0;
         r_ctrl_if_req  <= 1'b0;
         r_ctrl_load    <= 1'b0;
         r_ctrl_save    <= 1'b0;
         r_ctrl_addr    <= '0;
         r_ctrl_wdata   <= '0;
         r_ctrl_len     <= '0;
         r_ctrl_signed  <= 1'b0;
      end else begin
         r_if_done <= 1'b0;
         r_ls_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_ls) begin
                  r_state       <= LS_BUSY;
                  r_ctrl_load   <= !ls_we;
                  r_ctrl_save   <= ls_we;
                  r_ctrl_addr   <= ls_addr;
                  r_ctrl_wdata  <= ls_wdata;
                  r_ctrl_len    <= w_len_fix;
                  r_ctrl_signed <= ls_signed;
               end else if (w_grant_if) begin
                  r_state       <= IF_BUSY;
                  r_ctrl_if_req <= 1'b1;
                  r_ctrl_addr   <= if_addr;
                  r_ctrl_wdata  <= '0;
                  r_ctrl_len    <= 3'd4;
                  r_ctrl_signed <= 1'b0;
                  // A redirect in the grant cycle already makes this fetch stale.
                  r_kill        <= flush;
               end
            end
            IF_BUSY: begin
               if (ctrl_inst_flag) begin
                  r_state       <= COOL;
                  r_ctrl_if_req <= 1'b0;
                  r_kill        <= 1'b0;
                  // Flush arriving together with the completion also kills it.
                  if (!(r_kill || flush)) begin
                     r_if_done      <= 1'b1;
                     r_if_inst      <= ctrl_inst;
                     r_if_done_addr <= r_ctrl_addr;
                  end
               end else if (flush) begin
                  r_kill <= 1'b1;
               end
            end
            LS_BUSY: begin
               if (ctrl_done) begin
                  r_state     <= COOL;
                  r_ctrl_load <= 1'b0;
                  r_ctrl_save <= 1'b0;
                  r_ls_done   <= 1'b1;
                  r_ls_rdata  <= ctrl_data;
               end
            end
            // One quiet cycle so a fresh command never overlaps a lingering
            // downstream done.
            COOL:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_done      = r_if_done;
   assign if_inst      = r_if_inst;
   assign if_done_addr = r_if_done_addr;
   assign ls_done      = r_ls_done;
   assign ls_rdata     = r_ls_rdata;
   assign ctrl_if_req  = r_ctrl_if_req;
   assign ctrl_load    = r_ctrl_load;
   assign ctrl_save    = r_ctrl_save;
   assign ctrl_addr    = r_ctrl_addr;
   assign ctrl_wdata   = r_ctrl_wdata;
   assign ctrl_len     = r_ctrl_len;
   assign ctrl_signed  = r_ctrl_signed;
   assign dbg_state    = r_state;

endmodule
